// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with binary wrap-bit pointers, occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and an
// optional first-word-fall-through read port.
//
// Handshake: a write is taken when wr_en=1 and full=0 at the rising edge; a
// read/pop is taken when rd_en=1 and empty=0 at the rising edge. Both are
// judged on the registered state before the edge, so a same-cycle read never
// frees space for a write and a same-cycle write never feeds a read.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0] L_DEPTH = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] L_AF    = CW'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] L_AE    = CW'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] L_ONE   = CW'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    // Status decodes only from the registered count.
    assign w_full       = (r_count == L_DEPTH);
    assign w_empty      = (r_count == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= L_AF);
    assign almost_empty = (r_count <= L_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc  = wr_en & ~w_full;
    assign w_rd_acc  = rd_en & ~w_empty;
    assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
    assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

    // Storage: written on accepted writes only, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[w_wr_addr] <= wr_data;
        end
    end

    // Write and read pointers advance on their accepted transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + L_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + L_ONE;
            end
        end
    end

    // Occupancy: +1 on write only, -1 on read only, unchanged otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + L_ONE;
                2'b01:   r_count <= r_count - L_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is always presented; valid whenever the FIFO holds data.
        assign rd_data  = r_mem[w_rd_addr];
        assign rd_valid = ~w_empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_rd_data;
        logic                  r_rd_valid;

        // Registered read: data lands one cycle after the accepting edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_rd_data <= r_mem[w_rd_addr];
                end
            end
        end

        assign rd_data  = r_rd_data;
        assign rd_valid = r_rd_valid;
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a standard-read and an FWFT instance share one
// stimulus stream and are compared against a queue-based reference model.
module tb_sync_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;

  logic          s_full, s_af, s_rd_valid, s_empty, s_ae, s_ov, s_un;
  logic [DW-1:0] s_rd_data;
  logic [AW:0]   s_count;
  logic          f_full, f_af, f_rd_valid, f_empty, f_ae, f_ov, f_un;
  logic [DW-1:0] f_rd_data;
  logic [AW:0]   f_count;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
                   .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(s_full), .almost_full(s_af), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty),
    .almost_empty(s_ae), .count(s_count), .err_clr(err_clr),
    .overflow(s_ov), .underflow(s_un)
  );

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
                   .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(f_full), .almost_full(f_af), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
    .almost_empty(f_ae), .count(f_count), .err_clr(err_clr),
    .overflow(f_ov), .underflow(f_un)
  );

  // scoreboard / reference model
  logic [DW-1:0] exp_q[$];
  bit            m_ov = 1'b0;
  bit            m_un = 1'b0;
  bit            m_rv = 1'b0;
  logic [DW-1:0] m_rd = '0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the pre-edge occupancy.
  task automatic model_edge(input bit w, input logic [DW-1:0] d, input bit r,
                            input bit c, input bit rs);
    int n;
    bit was_full, was_empty;
    if (rs) begin
      exp_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      m_rv = 1'b0;
      m_rd = '0;
      return;
    end
    n = exp_q.size();
    was_full = (n == DEPTH);
    was_empty = (n == 0);
    m_rv = 1'b0;
    if (r && !was_empty) begin
      m_rd = exp_q.pop_front();
      m_rv = 1'b1;
    end
    if (w && !was_full) exp_q.push_back(d);
    if (w && was_full) m_ov = 1'b1;
    else if (c) m_ov = 1'b0;
    if (r && was_empty) m_un = 1'b1;
    else if (c) m_un = 1'b0;
  endtask

  task automatic compare_all();
    int n;
    n = exp_q.size();
    chk("s_count", 32'(s_count), 32'(n));
    chk("f_count", 32'(f_count), 32'(n));
    chk("s_empty", 32'(s_empty), 32'(n == 0));
    chk("f_empty", 32'(f_empty), 32'(n == 0));
    chk("s_full", 32'(s_full), 32'(n == DEPTH));
    chk("f_full", 32'(f_full), 32'(n == DEPTH));
    chk("s_af", 32'(s_af), 32'(n >= AF));
    chk("f_af", 32'(f_af), 32'(n >= AF));
    chk("s_ae", 32'(s_ae), 32'(n <= AE));
    chk("f_ae", 32'(f_ae), 32'(n <= AE));
    chk("s_ov", 32'(s_ov), 32'(m_ov));
    chk("f_ov", 32'(f_ov), 32'(m_ov));
    chk("s_un", 32'(s_un), 32'(m_un));
    chk("f_un", 32'(f_un), 32'(m_un));
    chk("s_rd_valid", 32'(s_rd_valid), 32'(m_rv));
    chk("s_rd_data", 32'(s_rd_data), 32'(m_rd));
    chk("f_rd_valid", 32'(f_rd_valid), 32'(n != 0));
    if (n != 0) chk("f_rd_data", 32'(f_rd_data), 32'(exp_q[0]));
  endtask

  // driver: apply inputs, take one edge, check outputs 1 time unit later
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                      input bit c, input bit rs);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    err_clr = c;
    rst = rs;
    @(posedge clk);
    model_edge(w, d, r, c, rs);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (exp_q.size() != 0) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [DW-1:0] fill_v[4];
    logic [DW-1:0] d;
    fill_v[0] = 8'h11; fill_v[1] = 8'h22; fill_v[2] = 8'h33; fill_v[3] = 8'h44;

    // reset state
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_ae", 32'(s_ae), 32'd1);
    chk("rst_rd_data", 32'(s_rd_data), 32'd0);
    idle();

    // fill to full, watching the threshold flags
    for (int i = 0; i < 4; i++) begin
      step(1'b1, fill_v[i], 1'b0, 1'b0, 1'b0);
      chk("fill_count", 32'(s_count), 32'(i + 1));
    end
    chk("fill_full", 32'(s_full), 32'd1);

    // write while full
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("ovf_flag", 32'(s_ov), 32'd1);
    chk("ovf_count", 32'(s_count), 32'd4);

    // drain in order, 0x55 must never appear
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("drain_data", 32'(s_rd_data), 32'(fill_v[i]));
    end
    idle();
    chk("drain_valid_low", 32'(s_rd_valid), 32'd0);

    // read while empty, then clear
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("unf_flag", 32'(s_un), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("clr_ov", 32'(s_ov), 32'd0);
    chk("clr_un", 32'(s_un), 32'd0);

    // err_clr together with a new overflow
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("clr_vs_ovf", 32'(s_ov), 32'd1);

    // full: read accepted, write rejected
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("full_rw_count", 32'(s_count), 32'd3);
    chk("full_rw_data", 32'(s_rd_data), 32'h60);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // count=2, simultaneous traffic wraps the pointers
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
      chk("sim_count", 32'(s_count), 32'd2);
    end
    drain();

    // fall-through presentation and pop
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("fwft_valid", 32'(f_rd_valid), 32'd1);
    chk("fwft_data", 32'(f_rd_data), 32'hA5);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);
    chk("fwft_pop_valid", 32'(f_rd_valid), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // write at empty with a same-cycle read
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    chk("wr_empty_un", 32'(f_un), 32'd1);
    chk("wr_empty_cnt", 32'(f_count), 32'd1);
    chk("wr_empty_data", 32'(f_rd_data), 32'h3C);

    // reset mid-operation at count=3 with overflow set
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(s_count), 32'd3);
    step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_count", 32'(s_count), 32'd0);
    chk("rst_mid_empty", 32'(f_empty), 32'd1);
    chk("rst_mid_ov", 32'(s_ov), 32'd0);
    chk("rst_mid_valid", 32'(s_rd_valid), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      d = 8'($urandom_range(0, 255));
      step($urandom_range(0, 99) < 55, d, $urandom_range(0, 99) < 50,
           $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
